mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two, >= 4).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states between accept and response (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_wdata  input  32  write data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle pulse marking a completed request.
REQ-011 SHALL have port rsp_rdata  output  32  read data, valid only with rsp_valid.
REQ-012 SHALL have port rsp_err  output  1  out-of-range flag, valid with rsp_valid (tied 0 without MEM_RANGE_CHECK_EN).
REQ-013 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; the handshake occurs when req_valid and req_ready are both 1 on a rising edge.
REQ-016 SHALL, on handshake, latch req_addr/req_we/req_wdata and go to WAIT, loading the wait counter with WAIT_CYCLES-1; if WAIT_CYCLES=0 go directly to RESP.
REQ-017 SHALL, in WAIT, decrement the counter each cycle and move to RESP on the edge where the counter is 0.
REQ-018 SHALL commit a write and capture read data on the edge entering RESP, using word index = latched addr[log2(DEPTH_WORDS)+1:2].
REQ-019 SHALL assert rsp_valid for exactly the one RESP cycle, then return to IDLE; latency from handshake edge to rsp_valid high is WAIT_CYCLES+1 cycles.
REQ-020 SHALL drive rsp_rdata = stored word for reads and 0 for writes; rsp_rdata is 0 whenever rsp_valid=0.
REQ-021 SHALL ignore req_valid outside IDLE, with no queueing; the initiator holds its request until req_ready.
REQ-022 SHALL give a read following a write to the same address the newly written data.
REQ-023 SHALL accept no request in RESP; the earliest next handshake is the cycle after rsp_valid, so back-to-back throughput is one request per WAIT_CYCLES+2 cycles.

Reset
REQ-024 SHALL, with reset=1 on an edge, force IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and busy=0; req_ready SHALL be 1 in the cycle after reset.
REQ-025 SHALL, on reset mid-operation, abort the request with no response; a write is not committed if reset coincides with the commit edge.
REQ-026 SHALL leave memory contents unchanged by reset.

Configuration
REQ-027 SHALL, with MEM_RANGE_CHECK_EN defined, treat latched addr >= 4*DEPTH_WORDS as out of range: no write, rsp_rdata=0, rsp_err=1 with rsp_valid.
REQ-028 SHALL, without MEM_RANGE_CHECK_EN, wrap out-of-range addresses by index truncation and tie rsp_err to 0.

Structure
REQ-029 SHALL place the FSM state enum, the wait counter width (4) and the default DEPTH_WORDS/WAIT_CYCLES constants in shared package mem_resp_pkg.
REQ-030 SHALL isolate storage in sub-module mem_array: single-port, synchronous read and write, DEPTH_WORDS x 32.

Verification
REQ-031 SHALL cover: WAIT_CYCLES=2, write 0xDEADBEEF to 0x10 then read 0x10 -> each rsp_valid exactly 3 cycles after its handshake; the read returns 0xDEADBEEF.
REQ-032 SHALL cover: WAIT_CYCLES=0, read 0x0 after a write of 0x12345678 -> rsp_valid 1 cycle after the handshake with data 0x12345678.
REQ-033 SHALL cover: req_valid held high continuously -> req_ready low while busy; handshakes spaced exactly WAIT_CYCLES+2 cycles apart; no request lost or duplicated.
REQ-034 SHALL cover: with the macro, write to 0x400 at DEPTH_WORDS=256 -> rsp_err=1 and word 0 unchanged; without the macro -> word 0 overwritten and rsp_err=0.
REQ-035 SHALL cover: reset asserted during WAIT of a write of 0xA5A5A5A5 to 0x20 -> no rsp_valid, later read of 0x20 returns the prior value, req_ready=1 the cycle after reset.
REQ-036 SHALL cover: addr 0x13 vs 0x10 -> same word accessed (low bits ignored).

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the wait-state memory responder.
// Holds the FSM state encoding, wait counter width and default geometry.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam int CNT_W           = 4;
    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH_WORDS x 32 storage, synchronous read and write, one-cycle read latency.
// No reset on contents; read data is the pre-write value when en_i and we_i coincide.
module mem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[idx_i] <= wdata_i;
            end
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: one request at a time, response WAIT_CYCLES+1 cycles after the handshake; req_ready only in IDLE.
// Define MEM_RANGE_CHECK_EN to flag (and not write) addresses beyond the array; otherwise they wrap.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    idx_q;
    logic             we_q;
    logic [31:0]      wdata_q;
    logic             oor_q;
    logic             rsp_valid_q;
    logic             err_q;

    logic             req_oor;
    logic             commit;
    logic             in_idle;
    logic [AW-1:0]    acc_idx;
    logic             acc_we;
    logic             acc_oor;
    logic [31:0]      acc_wdata;
    logic [31:0]      mem_rdata;
    logic             unused_addr_bits;

`ifdef MEM_RANGE_CHECK_EN
    assign req_oor = |req_addr[31:AW+2];
`else
    assign req_oor = 1'b0;
`endif
    assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:AW+2]};

    assign in_idle = (state_q == ST_IDLE);

    // With zero wait states the access happens on the handshake edge, before the request is latched.
    assign acc_idx   = in_idle ? req_addr[AW+1:2] : idx_q;
    assign acc_we    = in_idle ? req_we           : we_q;
    assign acc_wdata = in_idle ? req_wdata        : wdata_q;
    assign acc_oor   = in_idle ? req_oor          : oor_q;

    assign commit = !reset &&
                    ((in_idle && req_valid && (WAIT_CYCLES == 0)) ||
                     ((state_q == ST_WAIT) && (cnt_q == '0)));

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_mem_array (
        .clk    (clk),
        .en_i   (commit),
        .we_i   (acc_we && !acc_oor),
        .idx_i  (acc_idx),
        .wdata_i(acc_wdata),
        .rdata_o(mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= commit;
            if (commit) begin
                err_q <= acc_oor;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        idx_q   <= req_addr[AW+1:2];
                        we_q    <= req_we;
                        wdata_q <= req_wdata;
                        oor_q   <= req_oor;
                        cnt_q   <= WAIT_LOAD;
                        state_q <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = in_idle;
    assign busy      = !in_idle;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_valid_q && err_q;
    assign rsp_rdata = (rsp_valid_q && !we_q && !err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states) driven with directed and random requests.
// Responses are checked against an array-based memory model kept in the bench.
module tb_mem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        req_we    [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl   [2][DEPTH];
    bit          known [2][DEPTH];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_responder #(
            .DEPTH_WORDS(DEPTH),
            .WAIT_CYCLES((g == 0) ? 2 : 0)
        ) u_dut (
            .clk      (clk),
            .reset    (reset[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_addr (req_addr[g]),
            .req_we   (req_we[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g]),
            .busy     (busy[g])
        );
    end

    function automatic int wait_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one accepted request to the model and return the expected response.
    task automatic model_apply(input int k, input logic [31:0] a, input logic we,
                               input logic [31:0] wd, output logic [31:0] er,
                               output logic ee, output bit kn);
        int idx;
        bit oor;
        idx = int'((a >> 2) % DEPTH);
`ifdef MEM_RANGE_CHECK_EN
        oor = (a >= 4 * DEPTH);
`else
        oor = 1'b0;
`endif
        ee = oor;
        er = '0;
        kn = 1'b1;
        if (we) begin
            if (!oor) begin
                mdl[k][idx]   = wd;
                known[k][idx] = 1'b1;
            end
        end else if (!oor) begin
            er = mdl[k][idx];
            kn = known[k][idx];
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return 32'h400 + $urandom_range(0, 63);
        return $urandom_range(0, 63);
    endfunction

    task automatic do_req(input int k, input logic [31:0] a, input logic we, input logic [31:0] wd);
        int n;
        logic [31:0] er;
        logic ee;
        bit kn;
        @(negedge clk);
        req_addr[k]  = a;
        req_we[k]    = we;
        req_wdata[k] = wd;
        req_valid[k] = 1'b1;
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", req_ready[k], 1);
        model_apply(k, a, we, wd, er, ee, kn);
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid[k] && n <= 20);
        chk("rsp_latency", n, wait_of(k) + 1);
        if (kn) chk("rsp_rdata", rsp_rdata[k], er);
        chk("rsp_err", rsp_err[k], ee);
        @(negedge clk);
        chk("rsp_pulse", rsp_valid[k], 0);
        chk("rdata_idle", rsp_rdata[k], 0);
        chk("ready_after", req_ready[k], 1);
    endtask

    // Write to 0x20 interrupted by reset on the d-th edge after the handshake.
    task automatic reset_mid(input int k, input int d);
        int n;
        int seen;
        @(negedge clk);
        req_addr[k]  = 32'h20;
        req_we[k]    = 1'b1;
        req_wdata[k] = 32'hA5A5A5A5;
        req_valid[k] = 1'b1;
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        repeat (d - 1) begin
            @(posedge clk);
            #1;
        end
        reset[k] = 1'b1;
        @(posedge clk);
        #1 reset[k] = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", req_ready[k], 1);
        chk("rst_mid_busy", busy[k], 0);
        seen = (rsp_valid[k] === 1'b1) ? 1 : 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[k] === 1'b1) seen++;
        end
        chk("rst_mid_no_rsp", seen, 0);
    endtask

    // Hold req_valid high across nreq back-to-back requests.
    task automatic stream(input int k, input int nreq);
        int issued;
        int got;
        int last_hs;
        int cyc;
        logic [31:0] er_q[$];
        logic        ee_q[$];
        bit          kn_q[$];
        logic [31:0] er;
        logic ee;
        bit kn;
        issued  = 0;
        got     = 0;
        last_hs = -1;
        cyc     = 0;
        @(negedge clk);
        req_addr[k]  = rand_addr();
        req_we[k]    = 1'($urandom_range(0, 1));
        req_wdata[k] = $urandom;
        req_valid[k] = 1'b1;
        while (got < nreq && cyc < 500) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (rsp_valid[k]) begin
                if (er_q.size() > 0) begin
                    er = er_q.pop_front();
                    ee = ee_q.pop_front();
                    kn = kn_q.pop_front();
                    if (kn) chk("stream_rdata", rsp_rdata[k], er);
                    chk("stream_err", rsp_err[k], ee);
                    got++;
                end else begin
                    chk("stream_extra_rsp", rsp_valid[k], 0);
                end
            end
            if (issued < nreq) begin
                if (req_ready[k]) begin
                    if (last_hs >= 0) chk("hs_spacing", cyc - last_hs, wait_of(k) + 2);
                    last_hs = cyc;
                    model_apply(k, req_addr[k], req_we[k], req_wdata[k], er, ee, kn);
                    er_q.push_back(er);
                    ee_q.push_back(ee);
                    kn_q.push_back(kn);
                    issued++;
                    @(posedge clk);
                    #1;
                    if (issued < nreq) begin
                        req_addr[k]  = rand_addr();
                        req_we[k]    = 1'($urandom_range(0, 1));
                        req_wdata[k] = $urandom;
                    end else begin
                        req_valid[k] = 1'b0;
                    end
                end else begin
                    chk("ready_vs_busy", busy[k], 1);
                end
            end
        end
        req_valid[k] = 1'b0;
        chk("stream_count", got, nreq);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset[k]     = 1'b1;
            req_valid[k] = 1'b0;
            req_addr[k]  = '0;
            req_we[k]    = 1'b0;
            req_wdata[k] = '0;
            for (int i = 0; i < DEPTH; i++) known[k][i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", req_ready[k], 1);
            chk("rst_busy", busy[k], 0);
            chk("rst_rsp_valid", rsp_valid[k], 0);
            chk("rst_rsp_rdata", rsp_rdata[k], 0);
            chk("rst_rsp_err", rsp_err[k], 0);
        end

        do_req(0, 32'h10, 1'b1, 32'hDEADBEEF);
        do_req(0, 32'h10, 1'b0, 32'h0);
        do_req(0, 32'h13, 1'b1, 32'h5A5A1234);
        do_req(0, 32'h10, 1'b0, 32'h0);
        do_req(1, 32'h0, 1'b1, 32'h12345678);
        do_req(1, 32'h0, 1'b0, 32'h0);

        for (int k = 0; k < 2; k++) begin
            do_req(k, 32'h0, 1'b1, 32'hCAFEF00D);
            do_req(k, 32'h400, 1'b1, 32'h0BADBEEF);
            do_req(k, 32'h0, 1'b0, 32'h0);
        end

        do_req(0, 32'h20, 1'b1, 32'h11111111);
        reset_mid(0, 1);
        do_req(0, 32'h20, 1'b0, 32'h0);
        reset_mid(0, 2);
        do_req(0, 32'h20, 1'b0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            do_req(i % 2, rand_addr(), 1'($urandom_range(0, 1)), $urandom);
        end

        stream(0, 10);
        stream(1, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
